// File: rtl/cond_logic_pipe_if.sv
// Execute-stage condition bus: instruction controls in, qualified writes and status out.
// SD_W is derived from NUM_SAVE so both ends of the bus agree on the stack-depth width.
interface cond_logic_pipe_if #(
   parameter int CNT_W    = 16,
   parameter int NUM_SAVE = 2
);
   localparam int SD_W = $clog2(NUM_SAVE + 1);

   logic             Stall;
   logic             Flush;
   logic             PCS;
   logic             RegW;
   logic             NoWrite;
   logic             MemW;
   logic [1:0]       FlagW;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic             FlagSave;
   logic             FlagRestore;
   logic             PCSrc;
   logic             RegWrite;
   logic             MemWrite;
   logic             CondEx;
   logic [3:0]       Flags;
   logic             CarryIn;
   logic [SD_W-1:0]  SaveDepth;
   logic             StackErr;
   logic [CNT_W-1:0] RetireCnt;
   logic [CNT_W-1:0] SquashCnt;

   modport master (
      output Stall, Flush, PCS, RegW, NoWrite, MemW, FlagW, Cond, ALUFlags,
             FlagSave, FlagRestore,
      input  PCSrc, RegWrite, MemWrite, CondEx, Flags, CarryIn, SaveDepth,
             StackErr, RetireCnt, SquashCnt
   );

   modport slave (
      input  Stall, Flush, PCS, RegW, NoWrite, MemW, FlagW, Cond, ALUFlags,
             FlagSave, FlagRestore,
      output PCSrc, RegWrite, MemWrite, CondEx, Flags, CarryIn, SaveDepth,
             StackErr, RetireCnt, SquashCnt
   );
endinterface

// File: rtl/cond_logic_pipe.sv
// ARM EX-stage condition unit: NZCV register, condition decode, flag save stack, perf counters.
// Qualified outputs are combinational (zero latency); state updates on CLK; Stall freezes all state.
module cond_logic_pipe #(
   parameter int CNT_W    = 16,
   parameter int NUM_SAVE = 2
) (
   input  logic              CLK,
   input  logic              RESETn,
   cond_logic_pipe_if.slave  bus
);
   localparam int SD_W  = $clog2(NUM_SAVE + 1);
   localparam int SLOTS = 1 << SD_W;
   localparam logic [SD_W-1:0] FULL = SD_W'(NUM_SAVE);
   localparam logic [SD_W-1:0] ONE  = SD_W'(1);

   logic [3:0]       flags_q, flags_d;
   logic [SD_W-1:0]  depth_q;
   logic             err_q;
   logic [CNT_W-1:0] ret_q, sq_q;
   logic [3:0]       stack_q [SLOTS];

   logic cond_ex, valid, ex;
   logic n, z, c, v;
   logic save_ok, rest_ok, err_set, full, empty;
   logic [SD_W-1:0] top_idx;

   assign n = flags_q[3];
   assign z = flags_q[2];
   assign c = flags_q[1];
   assign v = flags_q[0];

   always_comb begin
      cond_ex = 1'b0;
      case (bus.Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   assign valid = ~bus.Stall & ~bus.Flush;
   assign ex    = cond_ex & valid;

   assign bus.CondEx    = cond_ex;
   assign bus.PCSrc     = bus.PCS & ex;
   assign bus.RegWrite  = bus.RegW & ~bus.NoWrite & ex;
   assign bus.MemWrite  = bus.MemW & ex;
   assign bus.Flags     = flags_q;
   assign bus.CarryIn   = flags_q[1];
   assign bus.SaveDepth = depth_q;
   assign bus.StackErr  = err_q;
   assign bus.RetireCnt = ret_q;
   assign bus.SquashCnt = sq_q;

   // Flush does not block stack ops; simultaneous save+restore is treated as misuse.
   assign full    = (depth_q == FULL);
   assign empty   = (depth_q == '0);
   assign top_idx = depth_q - ONE;
   assign save_ok = ~bus.Stall & bus.FlagSave & ~bus.FlagRestore & ~full;
   assign rest_ok = ~bus.Stall & bus.FlagRestore & ~bus.FlagSave & ~empty;
   assign err_set = ~bus.Stall & ((bus.FlagSave & bus.FlagRestore) |
                                  (bus.FlagSave & full) |
                                  (bus.FlagRestore & empty));

   always_comb begin
      flags_d = flags_q;
      if (ex) begin
         if (bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
         if (bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
      end
      if (rest_ok) flags_d = stack_q[top_idx];
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         flags_q <= 4'b0000;
         depth_q <= '0;
         err_q   <= 1'b0;
         ret_q   <= '0;
         sq_q    <= '0;
      end else begin
         flags_q <= flags_d;
         if (save_ok)      depth_q <= depth_q + ONE;
         else if (rest_ok) depth_q <= depth_q - ONE;
         if (err_set)      err_q   <= 1'b1;
         if (valid) begin
            if (cond_ex && ret_q != '1)      ret_q <= ret_q + CNT_W'(1);
            else if (!cond_ex && sq_q != '1) sq_q  <= sq_q + CNT_W'(1);
         end
      end
   end

   // Stack contents need no reset; depth alone defines which entries are live.
   always_ff @(posedge CLK) begin
      if (save_ok) stack_q[depth_q] <= flags_q;
   end
endmodule

// File: tb/tb_cond_logic_pipe.sv
// Scoreboarded bench for cond_logic_pipe: driver pushes model predictions, monitor pops and compares.
module tb_cond_logic_pipe;
   localparam int CNT_W = 4;
   localparam int NSAVE = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic CLK = 1'b0;
   logic RESETn = 1'b0;
   always #5 CLK = ~CLK;

   cond_logic_pipe_if #(.CNT_W(CNT_W), .NUM_SAVE(NSAVE)) bus ();
   cond_logic_pipe #(.CNT_W(CNT_W), .NUM_SAVE(NSAVE)) dut (
      .CLK(CLK), .RESETn(RESETn), .bus(bus)
   );

   typedef struct {
      logic stall, flush, pcs, regw, nowr, memw, save, rest;
      logic [1:0] flagw;
      logic [3:0] cond, alu;
   } stim_t;

   typedef struct {
      logic cex, pcsrc, regwr, memwr, carry, err;
      logic [3:0] flags;
      int depth, ret, sq;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   logic [3:0] m_flags;
   logic [3:0] m_stack[$];
   bit m_err;
   int m_ret, m_sq;

   function automatic bit cond_true(input logic [3:0] cc, input logic [3:0] f);
      bit nn, zz, cy, vv;
      nn = f[3]; zz = f[2]; cy = f[1]; vv = f[0];
      case (cc)
         0: return zz;           1: return !zz;
         2: return cy;           3: return !cy;
         4: return nn;           5: return !nn;
         6: return vv;           7: return !vv;
         8: return cy && !zz;    9: return !cy || zz;
         10: return nn == vv;    11: return nn != vv;
         12: return !zz && (nn == vv);
         13: return zz || (nn != vv);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic stim_t mk(input logic [3:0] cond, input logic pcs, input logic regw,
                                input logic nowr, input logic memw, input logic [1:0] flagw,
                                input logic [3:0] alu, input logic stall, input logic flush,
                                input logic save, input logic rest);
      stim_t s;
      s.cond = cond; s.pcs = pcs; s.regw = regw; s.nowr = nowr; s.memw = memw;
      s.flagw = flagw; s.alu = alu; s.stall = stall; s.flush = flush;
      s.save = save; s.rest = rest;
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, predict, optionally pulse reset before the next posedge.
   task automatic cycle(input stim_t s, input bit rst);
      exp_t e;
      bit valid, ce, ex;
      logic [3:0] nf;
      @(negedge CLK);
      bus.Stall = s.stall; bus.Flush = s.flush; bus.PCS = s.pcs; bus.RegW = s.regw;
      bus.NoWrite = s.nowr; bus.MemW = s.memw; bus.FlagW = s.flagw; bus.Cond = s.cond;
      bus.ALUFlags = s.alu; bus.FlagSave = s.save; bus.FlagRestore = s.rest;
      if (rst) begin
         RESETn = 1'b0;
         m_flags = 4'b0000; m_stack.delete(); m_err = 0; m_ret = 0; m_sq = 0;
      end
      #1;
      valid = !s.stall && !s.flush;
      ce = cond_true(s.cond, m_flags);
      ex = ce && valid;
      e.cex = ce; e.pcsrc = s.pcs && ex; e.regwr = s.regw && !s.nowr && ex;
      e.memwr = s.memw && ex; e.carry = m_flags[1]; e.flags = m_flags;
      e.depth = m_stack.size(); e.err = m_err; e.ret = m_ret; e.sq = m_sq;
      q.push_back(e);
      if (rst) begin
         #3;
         RESETn = 1'b1;
      end
      nf = m_flags;
      if (ex && s.flagw[1]) nf[3:2] = s.alu[3:2];
      if (ex && s.flagw[0]) nf[1:0] = s.alu[1:0];
      if (!s.stall) begin
         if (s.save && s.rest) m_err = 1;
         else if (s.save) begin
            if (m_stack.size() == NSAVE) m_err = 1;
            else m_stack.push_back(m_flags);
         end else if (s.rest) begin
            if (m_stack.size() == 0) m_err = 1;
            else nf = m_stack.pop_back();
         end
      end
      if (valid) begin
         if (ce) m_ret = (m_ret < CMAX) ? m_ret + 1 : CMAX;
         else    m_sq  = (m_sq  < CMAX) ? m_sq  + 1 : CMAX;
      end
      m_flags = nf;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("CondEx",    32'(bus.CondEx),    32'(e.cex));
            check("PCSrc",     32'(bus.PCSrc),     32'(e.pcsrc));
            check("RegWrite",  32'(bus.RegWrite),  32'(e.regwr));
            check("MemWrite",  32'(bus.MemWrite),  32'(e.memwr));
            check("CarryIn",   32'(bus.CarryIn),   32'(e.carry));
            check("Flags",     32'(bus.Flags),     32'(e.flags));
            check("SaveDepth", 32'(bus.SaveDepth), 32'(e.depth));
            check("StackErr",  32'(bus.StackErr),  32'(e.err));
            check("RetireCnt", 32'(bus.RetireCnt), 32'(e.ret));
            check("SquashCnt", 32'(bus.SquashCnt), 32'(e.sq));
         end
      end
   end

   initial begin : driver
      stim_t s;
      int wait_cnt;
      bus.Stall = 0; bus.Flush = 0; bus.PCS = 0; bus.RegW = 0; bus.NoWrite = 0;
      bus.MemW = 0; bus.FlagW = 0; bus.Cond = 0; bus.ALUFlags = 0;
      bus.FlagSave = 0; bus.FlagRestore = 0;
      m_flags = 0; m_err = 0; m_ret = 0; m_sq = 0;
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 1);
      // Preload 1111, then reset between edges: EQ fails, NE passes afterwards.
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b11, 4'hF, 0, 0, 0, 0), 0);
      cycle(mk(4'h0, 1, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 1);
      cycle(mk(4'h1, 1, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      // CMP then branches
      cycle(mk(4'hE, 0, 1, 1, 0, 2'b11, 4'h4, 0, 0, 0, 0), 0);
      cycle(mk(4'h0, 1, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      cycle(mk(4'h8, 1, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      cycle(mk(4'h9, 1, 1, 0, 1, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      // Partial writes
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 1);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b10, 4'hF, 0, 0, 0, 0), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b01, 4'h3, 0, 0, 0, 0), 0);
      cycle(mk(4'hF, 0, 0, 0, 0, 2'b11, 4'h0, 0, 0, 0, 0), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      // Stall / Flush, then 3 retired and 2 squashed
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 1);
      cycle(mk(4'hE, 0, 0, 0, 1, 2'b11, 4'hA, 1, 0, 0, 0), 0);
      cycle(mk(4'hE, 0, 0, 0, 1, 2'b11, 4'hA, 0, 1, 0, 0), 0);
      for (int i = 0; i < 3; i++) cycle(mk(4'hE, 0, 0, 0, 1, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      for (int i = 0; i < 2; i++) cycle(mk(4'h0, 0, 0, 0, 1, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 1, 0, 0, 0), 0);
      // Save stack
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 1);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b11, 4'h8, 0, 0, 0, 0), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b11, 4'h4, 0, 0, 1, 0), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b11, 4'h2, 0, 0, 1, 0), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 1, 0), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b11, 4'hF, 0, 0, 0, 1), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 1), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 1), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 1, 1, 1), 0);
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      // Saturation
      cycle(mk(4'hE, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), 1);
      for (int i = 0; i < 20; i++) cycle(mk(4'hE, 1, 1, 0, 1, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      for (int i = 0; i < 20; i++) cycle(mk(4'h0, 1, 1, 0, 1, 2'b00, 4'h0, 0, 0, 0, 0), 0);
      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         s.cond  = 4'($urandom_range(0, 15));
         s.pcs   = 1'($urandom);  s.regw = 1'($urandom);
         s.nowr  = 1'($urandom);  s.memw = 1'($urandom);
         s.flagw = 2'($urandom);  s.alu  = 4'($urandom);
         s.stall = ($urandom_range(0, 4) == 0);
         s.flush = ($urandom_range(0, 5) == 0);
         s.save  = ($urandom_range(0, 5) == 0);
         s.rest  = ($urandom_range(0, 5) == 0);
         cycle(s, $urandom_range(0, 79) == 0);
      end
      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 10) begin
         @(negedge CLK);
         wait_cnt++;
      end
      #5;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
